// File: rtl/fetch_stage_pkg.sv
// Shared constants and types for the instruction-fetch front end.
package fetch_stage_pkg;

    localparam int unsigned ADDR_W_DEF     = 32;
    localparam int unsigned INST_W_DEF     = 32;
    localparam int unsigned INST_BYTES_DEF = 4;
    localparam int unsigned DEPTH_DEF      = 4;

    localparam logic [31:0] ZERO_WORD      = '0;
    localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = ZERO_WORD;

    typedef enum logic {
        ST_HALT,
        ST_RUN
    } run_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// ROM request, redirect and decode handshake bundle for fetch_stage.
interface fetch_stage_if import fetch_stage_pkg::*; #(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned INST_W = INST_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic [INST_W-1:0] rom_data_i;
    logic [ADDR_W-1:0] rom_addr_o;
    logic              rom_ce_o;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              id_ready_i;
    logic              id_valid_o;
    logic [ADDR_W-1:0] id_pc_o;
    logic [INST_W-1:0] id_inst_o;
    logic [CNT_W-1:0]  count_o;

    modport master (
        input  rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
        output rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );

    modport slave (
        output rom_data_i, redirect_i, redirect_pc_i, id_ready_i,
        input  rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o, count_o
    );

endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head reads zero while empty.
module fetch_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CNT_W'(DEPTH));
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch front end: PC generator, ROM request and instruction queue to decode.
module fetch_stage import fetch_stage_pkg::*; #(
    parameter int unsigned        ADDR_W     = ADDR_W_DEF,
    parameter int unsigned        INST_W     = INST_W_DEF,
    parameter int unsigned        INST_BYTES = INST_BYTES_DEF,
    parameter logic [ADDR_W-1:0]  RESET_PC   = ADDR_W'(RESET_PC_DEF),
    parameter int unsigned        DEPTH      = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst,
    fetch_stage_if.master   bus
);

    localparam int unsigned       CNT_W      = $clog2(DEPTH) + 1;
    localparam int unsigned       ENTRY_W    = ADDR_W + INST_W;
    localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(INST_BYTES);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(INST_BYTES - 1));

    run_state_e          state;
    logic [ADDR_W-1:0]   pc;
    logic                push;
    logic                pop;
    logic                valid;
    logic                full;
    logic                empty;
    logic [CNT_W-1:0]    count;
    logic [ENTRY_W-1:0]  head;

    // Fetch never looks at id_ready: a full queue blocks the push even when a pop frees a slot.
    assign push  = (state == ST_RUN) & ~full & ~bus.redirect_i & ~rst;
    assign valid = ~empty & ~bus.redirect_i & ~rst;
    assign pop   = valid & bus.id_ready_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_HALT;
            pc    <= RESET_PC;
        end else begin
            state <= ST_RUN;
            if (bus.redirect_i) begin
                pc <= bus.redirect_pc_i & ALIGN_MASK;
            end else if (push) begin
                pc <= pc + STEP;
            end
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.redirect_i),
        .push  (push),
        .pop   (pop),
        .din   ({pc, bus.rom_data_i}),
        .head  (head),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    assign bus.rom_addr_o = pc;
    assign bus.rom_ce_o   = push;
    assign bus.id_valid_o = valid;
    assign bus.id_pc_o    = head[ENTRY_W-1 -: ADDR_W];
    assign bus.id_inst_o  = head[INST_W-1:0];
    assign bus.count_o    = count;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed scenarios followed by randomized redirect/stall/reset traffic.
module tb_fetch_stage;

    localparam int unsigned DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_stage_if #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH)) bus();

    fetch_stage #(
        .ADDR_W     (32),
        .INST_W     (32),
        .INST_BYTES (4),
        .RESET_PC   (32'h0),
        .DEPTH      (DEPTH)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    assign bus.rom_data_i = rom_word(bus.rom_addr_o);

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] exp_q[$];
    logic [31:0] m_pc = 32'h0;
    bit          m_run = 1'b0;
    bit          cur_fetch = 1'b0;
    bit          checking = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every cycle, pops the scoreboard on each handshake.
    always @(negedge clk) begin
        if (checking) begin
            bit ev;
            ev = (exp_q.size() != 0) && !bus.redirect_i && !rst;
            check("count", 64'(bus.count_o), 64'(exp_q.size()));
            check("rom_ce", 64'(bus.rom_ce_o), 64'(cur_fetch));
            check("rom_addr", 64'(bus.rom_addr_o), 64'(m_pc));
            check("id_valid", 64'(bus.id_valid_o), 64'(ev));
            if (ev) begin
                check("head", {bus.id_pc_o, bus.id_inst_o}, exp_q[0]);
                if (bus.id_ready_i) void'(exp_q.pop_front());
            end else if (exp_q.size() == 0) begin
                check("empty_head", {bus.id_pc_o, bus.id_inst_o}, 64'h0);
            end
        end
    end

    task automatic drive(input bit r, input bit rd, input logic [31:0] tgt, input bit rdy);
        rst               = r;
        bus.redirect_i    = rd;
        bus.redirect_pc_i = tgt;
        bus.id_ready_i    = rdy;
        cur_fetch = !r && !rd && m_run && (exp_q.size() < DEPTH);
    endtask

    // Advance the reference model across one edge using the inputs held during the cycle.
    task automatic tick();
        @(posedge clk);
        #1;
        if (rst) begin
            exp_q.delete();
            m_pc  = 32'h0;
            m_run = 1'b0;
        end else begin
            if (bus.redirect_i) begin
                exp_q.delete();
                m_pc = bus.redirect_pc_i & ~32'h3;
            end else if (cur_fetch) begin
                exp_q.push_back({m_pc, rom_word(m_pc)});
                m_pc = m_pc + 32'd4;
            end
            m_run = 1'b1;
        end
        checking = 1'b1;
    endtask

    task automatic step(input bit r, input bit rd, input logic [31:0] tgt, input bit rdy);
        drive(r, rd, tgt, rdy);
        tick();
    endtask

    task automatic fill_to(input int n);
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() == n) break;
            step(1'b0, 1'b0, 32'h0, 1'b0);
        end
        check("fill_count", 64'(bus.count_o), 64'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          r;
        bit          rd;
        bit          rdy;
        logic [31:0] tgt;

        // Reset release with decode always ready
        repeat (2) step(1'b1, 1'b0, 32'h0, 1'b1);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Decode stalled for 10 cycles: queue fills to DEPTH and fetch stops at 16
        step(1'b1, 1'b0, 32'h0, 1'b0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b0);
        check("stall_count", 64'(bus.count_o), 64'd4);
        check("stall_rom_addr", 64'(bus.rom_addr_o), 64'h10);
        check("stall_rom_ce", 64'(bus.rom_ce_o), 64'd0);
        repeat (10) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect with three entries queued, unaligned target
        step(1'b1, 1'b0, 32'h0, 1'b0);
        fill_to(3);
        step(1'b0, 1'b1, 32'h0000_0103, 1'b1);
        check("redir_count", 64'(bus.count_o), 64'd0);
        check("redir_rom_addr", 64'(bus.rom_addr_o), 64'h100);
        repeat (6) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Redirect against a full queue with decode ready
        fill_to(4);
        step(1'b0, 1'b1, 32'h0000_0040, 1'b1);
        check("redir_full_count", 64'(bus.count_o), 64'd0);
        check("redir_full_rom_addr", 64'(bus.rom_addr_o), 64'h40);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // PC wrap at the top of the address space
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b1);
        check("wrap_top", 64'(bus.rom_addr_o), 64'hFFFF_FFFC);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        check("wrap_zero", 64'(bus.rom_addr_o), 64'h0);
        repeat (4) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Reset mid-stream with two entries queued
        step(1'b0, 1'b1, 32'h0000_0200, 1'b1);
        fill_to(2);
        step(1'b1, 1'b0, 32'h0, 1'b1);
        check("rst_count", 64'(bus.count_o), 64'd0);
        check("rst_rom_addr", 64'(bus.rom_addr_o), 64'h0);
        drive(1'b0, 1'b0, 32'h0, 1'b1);
        #2;
        check("rst_rom_ce", 64'(bus.rom_ce_o), 64'd0);
        tick();
        repeat (8) step(1'b0, 1'b0, 32'h0, 1'b1);

        // Randomized traffic
        repeat (400) begin
            r   = ($urandom_range(63) == 0);
            rd  = ($urandom_range(9) == 0);
            rdy = ($urandom_range(9) < 7);
            tgt = $urandom;
            if ($urandom_range(3) == 0) tgt = 32'hFFFF_FFF0 | (tgt & 32'hF);
            step(r, rd, tgt, rdy);
        end

        @(negedge clk);
        #1;
        checking = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
